// File: rtl/master_spi.sv
// master_spi: SPI master, CPOL=1. mosi changes on sclk falling edges and miso
// is sampled on sclk rising edges, MSB first. Each accepted start request runs
// one full-duplex DATA_WIDTH-bit transfer. sclk_m is derived from clk_m, with
// CLK_DIV clk_m cycles per sclk half-period.
//
// Ports:
//   clk_m            system clock, all logic on its rising edge
//   rst              asynchronous active-high reset
//   start            transfer request, only looked at while idle
//   data_in_master   transmit word, captured when start is accepted
//   miso             serial data from the slave
//   sclk_m           SPI clock, idles high
//   ss               slave select, active low
//   mosi             serial data to the slave
//   data_out_master  last completely received word
//   busy             high for the duration of a transfer
//   done             one-cycle pulse when a transfer completes
module master_spi #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk_m,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in_master,
  input  logic                  miso,
  output logic                  sclk_m,
  output logic                  ss,
  output logic                  mosi,
  output logic [DATA_WIDTH-1:0] data_out_master,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  tc;
  logic                  last_bit;

  // Terminal count of the half-period divider: every sclk event happens here.
  assign tc       = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk_m or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SETUP;
      SETUP:   if (tc) state_nxt = SHIFT;
      // Leave SHIFT on the rising edge that samples the final bit.
      SHIFT:   if (tc && !sclk_m && last_bit) state_nxt = HOLD;
      HOLD:    if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_m or posedge rst) begin
    if (rst) begin
      sclk_m          <= 1'b1;
      ss              <= 1'b1;
      mosi            <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      data_out_master <= '0;
      tx_sr           <= '0;
      rx_sr           <= '0;
      div_cnt         <= '0;
      bit_cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // MSB goes out immediately so it is stable before the first falling edge.
            tx_sr   <= data_in_master;
            mosi    <= data_in_master[DATA_WIDTH-1];
            ss      <= 1'b0;
            busy    <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        SETUP: begin
          if (tc) begin
            // Falling edge 0: mosi already carries the MSB, nothing to shift.
            div_cnt <= '0;
            sclk_m  <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (tc) begin
            div_cnt <= '0;
            sclk_m  <= ~sclk_m;
            if (!sclk_m) begin
              // Rising edge: capture miso into the LSB.
              rx_sr   <= (rx_sr << 1) | {{(DATA_WIDTH-1){1'b0}}, miso};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              // Falling edge k>=1: present the next bit.
              tx_sr <= tx_sr << 1;
              mosi  <= tx_sr[DATA_WIDTH-2];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (tc) begin
            div_cnt         <= '0;
            ss              <= 1'b1;
            busy            <= 1'b0;
            done            <= 1'b1;
            data_out_master <= rx_sr;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
          div_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/master_spi.md
Name: master_spi

Overview:
- SPI master that generates sclk, ss and mosi for slave_spi and captures miso; DATA_WIDTH-bit full-duplex transfer per start request.
- Mode fixed: sclk idle high (CPOL=1), mosi driven on falling edges, miso sampled on rising edges, MSB first.
- Sits between the system logic (parallel data/handshake) and the SPI pins; sclk is derived from clk_m by a programmable divider.

Parameters:
DATA_WIDTH, 8, bits per transfer (>=2)
CLK_DIV, 2, clk_m cycles per sclk half-period (>=1; 0 illegal)

Ports:
clk_m  input  1  master system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  transfer request, sampled only in IDLE
data_in_master  input  DATA_WIDTH  transmit word, latched when start is accepted
miso  input  1  serial data from slave
sclk_m  output  1  SPI clock to slave (sclk_s)
ss  output  1  slave select, active low
mosi  output  1  serial data to slave
data_out_master  output  DATA_WIDTH  last received word
busy  output  1  high while a transfer is in progress
done  output  1  one-cycle pulse at transfer completion

Behaviour:
- Reset (async, any time including mid-transfer): sclk_m=1, ss=1, mosi=0, busy=0, done=0, data_out_master=0, all counters cleared, FSM=IDLE. Partially received data is discarded and no done pulse is issued.
- FSM states: IDLE, SETUP, SHIFT, HOLD. All outputs are registered.
- Let T0 be the clk_m edge at which start=1 is sampled in IDLE.
  - At T0, latch data_in_master into the tx shift register.
  - ss goes to 0 and busy goes to 1.
  - mosi is driven with tx[DATA_WIDTH-1].
  - The FSM moves to SETUP.
- Timing of clock edges, with D=CLK_DIV and N=DATA_WIDTH:
  - SETUP lasts D cycles.
  - The divider counter runs 0..D-1 and toggles sclk_m at its terminal count.
  - For k=0..N-1, falling edge k occurs at T0+(2k+1)D and rising edge k at T0+(2k+2)D.
- Falling edge k:
  - For k=0, mosi keeps the MSB.
  - For k>=1, tx shifts left and mosi = next bit, so bit N-1-k is presented.
- Rising edge k: miso is shifted into the LSB of the rx register.
- After rising edge N-1 (T0+2N·D), the FSM enters HOLD. sclk_m stays high for D cycles.
- At T0+(2N+1)D, the following all happen on the same edge:
  - ss returns to 1 and busy returns to 0.
  - done=1 for exactly one cycle.
  - data_out_master is loaded with the rx register.
  - The FSM returns to IDLE.
- Example (DATA_WIDTH=8, CLK_DIV=2): falling edges at T0+2, 6, …, 30; rising edges at T0+4, 8, …, 32; ss high and done at T0+34.
- start is ignored while busy=1, with no queuing.
- start sampled on the cycle after done begins a new transfer. ss is therefore high for at least 1 cycle between transfers.
- data_in_master changes after T0 do not affect the current transfer.
- data_out_master holds its value until the next completed transfer.
- Exactly N falling and N rising sclk_m edges occur per transfer. sclk_m never toggles while ss=1.
- mosi is held at its last value in IDLE; it is don't-care while ss=1.

Test Plan:
1. Reset check: assert rst for 3 cycles, then release, with start=0. Required: sclk_m=1, ss=1, mosi=0, busy=0, done=0, data_out_master=8'h00, and no sclk_m toggling for 50 cycles.
2. Loopback transfer: miso tied to mosi, data_in_master=8'hB2, one-cycle start pulse. Required:
   - mosi bit sequence 1,0,1,1,0,0,1,0 across the falling edges.
   - 8 falling and 8 rising sclk_m edges at the timing above.
   - ss low for exactly 34 cycles.
   - done pulse at T0+34.
   - data_out_master=8'hB2.
3. Fixed miso: tie miso=1 and send 8'h00 → data_out_master=8'hFF. Then tie miso=0 and send 8'hFF → data_out_master=8'h00, with mosi all 1s.
4. Start during busy: pulse start again at T0+10 with data_in_master=8'h55. Required: the pulse is ignored, exactly 8 edge pairs occur, a single done pulse is issued, and the transmitted word is still 8'hB2.
5. Reset mid-transfer: assert rst at T0+15. Required: immediate return to sclk_m=1, ss=1, busy=0, no done pulse, and data_out_master unchanged from its reset value. Then a fresh transfer after reset completes correctly.
6. Back-to-back and divider variant:
   - start held high continuously → a second transfer begins on the cycle after done, with ss high for exactly 1 cycle between transfers.
   - Repeat scenario 2 with CLK_DIV=1 → done at T0+17 and data_out_master=8'hB2.
